// File: rtl/line_buf_pingpong_ctrl.sv
// rtl/line_buf_pingpong_ctrl.sv - ping-pong line buffer write/read address controller
//
// Incoming pixels fill RAM A and RAM B alternately, one full line per bank.
// When a line completes ("swap"), the read side streams the just-filled bank
// out under rd_ready flow control while the other bank is being written.
//
// Parameters:
//   LINE_LEN  pixels per line (2..2**ADDR_W)
//   ADDR_W    RAM address width
// Ports:
//   clk         single clock, rising edge
//   aclr_n      asynchronous active-low reset
//   data_valid  one incoming pixel per asserted cycle
//   rama_wren   RAM A write enable (registered, 1 cycle after data_valid)
//   ramb_wren   RAM B write enable (registered, 1 cycle after data_valid)
//   wr_addr     write address shared by both RAMs
//   rd_ready    downstream accepts one read word this cycle
//   rd_en       read strobe for the bank chosen by rd_sel
//   rd_addr     read address shared by both RAMs
//   rd_sel      read bank select, 0 = RAM A, 1 = RAM B
//   rd_last     marks the final rd_en of a line
//   ovf         sticky overrun flag (a line finished before the previous was read out)
//   ovf_clr     synchronous clear for ovf (a simultaneous set wins)
//   ovf_cnt     8-bit saturating overrun count, present only with LBUF_OVF_CNT_EN
//
// Optional feature macro: LBUF_OVF_CNT_EN

module line_buf_pingpong_ctrl #(
  parameter int LINE_LEN = 1280,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              data_valid,
  output logic              rama_wren,
  output logic              ramb_wren,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  output logic              rd_last,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef LBUF_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  rd_state_t         state_q;
  rd_state_t         state_nxt;
  logic              wr_bank;
  logic [ADDR_W-1:0] wcnt;
  logic              swap;
  logic              overrun;

  // A swap is the cycle that accepts the last pixel of a line.
  assign swap = data_valid & (wcnt == LAST_ADDR);

  // Overrun: a new line is ready while the previous one is still being read
  // and this cycle is not its final read.
  assign overrun = swap & (state_q == R_RUN) & ~rd_last;

  // ---------------------------------------------------------------- write side
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_bank   <= 1'b0;
      wcnt      <= '0;
      rama_wren <= 1'b0;
      ramb_wren <= 1'b0;
      wr_addr   <= '0;
    end else begin
      rama_wren <= data_valid & ~wr_bank;
      ramb_wren <= data_valid & wr_bank;
      if (data_valid) begin
        wr_addr <= wcnt;
        if (swap) begin
          wcnt    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wcnt <= wcnt + ADDR_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------- read FSM: state
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= R_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ------------------------------------------------------ read FSM: next state
  // A swap always (re)starts a read, even on the final read of the old line.
  always_comb begin
    state_nxt = state_q;
    if (swap) begin
      state_nxt = R_RUN;
    end else if ((state_q == R_RUN) && rd_last) begin
      state_nxt = R_IDLE;
    end
  end

  // ---------------------------------------------------------- read FSM: outputs
  always_comb begin
    rd_en   = 1'b0;
    rd_last = 1'b0;
    if (state_q == R_RUN) begin
      rd_en   = rd_ready;
      rd_last = rd_ready & (rd_addr == LAST_ADDR);
    end
  end

  // --------------------------------------------------------- read address/bank
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rd_addr <= '0;
      rd_sel  <= 1'b0;
    end else if (swap) begin
      rd_sel  <= wr_bank;
      rd_addr <= '0;
    end else if (rd_en) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  // ------------------------------------------------------------- overrun flag
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ovf <= 1'b0;
    end else if (overrun) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef LBUF_OVF_CNT_EN
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ovf_cnt <= 8'd0;
    end else if (overrun) begin
      if (ovf_cnt != 8'hFF) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_cnt <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_line_buf_pingpong_ctrl.sv
// tb/tb_line_buf_pingpong_ctrl.sv - self-checking bench for line_buf_pingpong_ctrl

module tb_line_buf_pingpong_ctrl;

  localparam int L  = 4;
  localparam int AW = 11;

  logic          clk;
  logic          aclr_n;
  logic          data_valid;
  logic          rama_wren;
  logic          ramb_wren;
  logic [AW-1:0] wr_addr;
  logic          rd_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_sel;
  logic          rd_last;
  logic          ovf;
  logic          ovf_clr;
`ifdef LBUF_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  line_buf_pingpong_ctrl #(.LINE_LEN(L), .ADDR_W(AW)) dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .data_valid (data_valid),
    .rama_wren  (rama_wren),
    .ramb_wren  (ramb_wren),
    .wr_addr    (wr_addr),
    .rd_ready   (rd_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_sel     (rd_sel),
    .rd_last    (rd_last),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef LBUF_OVF_CNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: total pixels since reset decides bank and address;
  // the read side is "words still to read" of the line being streamed.
  int m_total;
  int m_rem;
  int m_rsel;
  int m_ovf;
  int m_cnt;
  int m_wa;
  int m_wb;
  int m_waddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_rem = 0; m_rsel = 0; m_ovf = 0; m_cnt = 0;
    m_wa = 0; m_wb = 0; m_waddr = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rama"}, rama_wren, 0);
    chk({tag, "_ramb"}, ramb_wren, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rd_sel"}, rd_sel, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_ovf"}, ovf, 0);
`ifdef LBUF_OVF_CNT_EN
    chk({tag, "_ovf_cnt"}, ovf_cnt, 0);
`endif
  endtask

  // Called just after a rising edge; drives inputs, checks at the falling
  // edge, advances the model, and returns just after the next rising edge.
  task automatic step(input logic dv, input logic rdy, input logic clr);
    int e_en, e_last, swap, ovr, bank;
    data_valid = dv;
    rd_ready   = rdy;
    ovf_clr    = clr;
    @(negedge clk);
    e_en   = (m_rem > 0 && rdy) ? 1 : 0;
    e_last = (e_en == 1 && m_rem == 1) ? 1 : 0;
    chk("rama_wren", rama_wren, m_wa);
    chk("ramb_wren", ramb_wren, m_wb);
    if (m_wa == 1 || m_wb == 1) chk("wr_addr", wr_addr, m_waddr);
    chk("rd_en", rd_en, e_en);
    chk("rd_last", rd_last, e_last);
    chk("rd_sel", rd_sel, m_rsel);
    if (m_rem > 0) chk("rd_addr", rd_addr, L - m_rem);
    chk("ovf", ovf, m_ovf);
`ifdef LBUF_OVF_CNT_EN
    chk("ovf_cnt", ovf_cnt, m_cnt);
`endif
    bank  = (m_total / L) % 2;
    swap  = (dv && (m_total % L) == L - 1) ? 1 : 0;
    m_wa  = (dv && bank == 0) ? 1 : 0;
    m_wb  = (dv && bank == 1) ? 1 : 0;
    if (dv) m_waddr = m_total % L;
    ovr = (swap == 1 && m_rem > 0 && e_last == 0) ? 1 : 0;
    if (e_en == 1) m_rem--;
    if (swap == 1) begin
      m_rsel = bank;
      m_rem  = L;
    end
    if (ovr == 1) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    if (dv) m_total++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr_n = 1'b0; data_valid = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    aclr_n = 1'b1;

    // Continuous stream with rd_ready high: bank alternation, read of each
    // line, and rd_last coinciding with the next swap.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Backpressure while two lines complete -> overrun, then clear.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset after 2 pixels of a line.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    data_valid = 1'b0;
    #2;
    aclr_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    aclr_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));

    // Many overruns (saturates ovf_cnt when present), then clear.
    for (int i = 0; i < L * 305; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
